// File: rtl/i2c_driver_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_driver_arbiter
//
// Purpose:
//   Shares one I2CTransceiver between NUM_PORTS client controllers (I/O
//   expander, sensor, EEPROM drivers, ...). Each client gets a private
//   request/ack/done handshake plus its own command/status structs. The bus
//   is granted round-robin and held for a whole transaction, until the
//   owner's done pulse.
//
// Optional feature:
//   Define I2C_ARBITER_TIMEOUT_EN to add a watchdog. If an owner stays busy
//   for TIMEOUT_CYCLES cycles, the arbiter sends a stop and waits for the
//   transceiver to go idle. It then pulses timeout_fault[owner] and releases
//   the bus. Without the macro, timeout_fault is tied to 0.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   client_request  [NUM_PORTS]  one-cycle request pulse per client
//   client_done     [NUM_PORTS]  one-cycle release pulse per client
//   client_ack      [NUM_PORTS]  one-cycle grant pulse per client
//   client_cin      NUM_PORTS x i2c_in_t   per-client commands
//   client_cout     NUM_PORTS x i2c_out_t  per-client status
//   driver_cin      i2c_in_t   command to the shared transceiver
//   driver_cout     i2c_out_t  status from the shared transceiver
//   owner           index of the current owner (debug)
//   owner_valid     1 while the bus is granted
//   timeout_fault   [NUM_PORTS]  one-cycle watchdog fault pulse
// ---------------------------------------------------------------------------

package i2c_driver_arbiter_pkg;

    // Command strobes and data towards the transceiver.
    typedef struct packed {
        logic       start_en;
        logic       stop_en;
        logic       tx_en;
        logic       rx_en;
        logic       rx_nack;
        logic [7:0] tx_data;
    } i2c_in_t;

    // Status from the transceiver.
    typedef struct packed {
        logic       busy;
        logic       tx_done;
        logic       ack_error;
        logic       rx_valid;
        logic [7:0] rx_data;
    } i2c_out_t;

    // What a port that does not own the bus sees: busy, and no strobes.
    localparam i2c_out_t I2C_OUT_BLOCKED = '{busy: 1'b1, default: '0};

endpackage

module i2c_driver_arbiter
    import i2c_driver_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         client_request,
    input  logic [NUM_PORTS-1:0]         client_done,
    output logic [NUM_PORTS-1:0]         client_ack,
    input  i2c_in_t                      client_cin  [NUM_PORTS],
    output i2c_out_t                     client_cout [NUM_PORTS],
    output i2c_in_t                      driver_cin,
    input  i2c_out_t                     driver_cout,
    output logic [$clog2(NUM_PORTS)-1:0] owner,
    output logic                         owner_valid,
    output logic [NUM_PORTS-1:0]         timeout_fault
);

    localparam int OW = $clog2(NUM_PORTS);

    // Reject out-of-range configurations at elaboration time.
    if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_driver_arbiter: NUM_PORTS must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN
    } state_t;

    state_t               state;
    logic [NUM_PORTS-1:0] pending;
    logic [OW-1:0]        rr_ptr;
    logic [NUM_PORTS-1:0] candidates;
    logic                 grant_found;
    logic [OW-1:0]        grant_idx;
    logic [OW-1:0]        search_idx;
    logic [NUM_PORTS-1:0] grant_onehot;

`ifdef I2C_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic          stop_pending;
`endif

    // Index that follows p, wrapping at NUM_PORTS (which need not be a power of 2).
    function automatic logic [OW-1:0] next_port(input logic [OW-1:0] p);
        if (int'(p) == NUM_PORTS - 1)
            return '0;
        else
            return p + 1'b1;
    endfunction

    // A request pulse arriving this cycle competes alongside the latched
    // ones, so it can win on the same edge it is sampled. The search starts
    // at rr_ptr and wraps; the first set bit wins.
    always_comb begin
        candidates  = pending | client_request;
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            search_idx = OW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!grant_found && candidates[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
        end
        grant_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx;
    end

    // Main controller. Every request pulse is OR-ed into pending, including
    // one from the current owner, so no pulse is lost. A grant clears only
    // the winner's bit. Releasing the bus moves rr_ptr past the old owner.
    // The grant happens only from IDLE, which forces one idle cycle between
    // owners.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pending     <= '0;
            rr_ptr      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            client_ack  <= '0;
`ifdef I2C_ARBITER_TIMEOUT_EN
            timer         <= '0;
            stop_pending  <= 1'b0;
            timeout_fault <= '0;
`endif
        end else begin
            client_ack <= '0;
            pending    <= pending | client_request;
`ifdef I2C_ARBITER_TIMEOUT_EN
            timeout_fault <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        client_ack  <= grant_onehot;
                        owner       <= grant_idx;
                        owner_valid <= 1'b1;
                        pending     <= candidates & ~grant_onehot;
                        state       <= ST_BUSY;
`ifdef I2C_ARBITER_TIMEOUT_EN
                        timer       <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (client_done[owner]) begin
                        state       <= ST_IDLE;
                        owner_valid <= 1'b0;
                        rr_ptr      <= next_port(owner);
                    end
`ifdef I2C_ARBITER_TIMEOUT_EN
                    // timer holds the number of BUSY cycles already spent.
                    else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state        <= ST_DRAIN;
                        stop_pending <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
`ifdef I2C_ARBITER_TIMEOUT_EN
                // Issue one stop cycle, then wait for the transceiver to go
                // idle before releasing. A late done from the stuck owner is
                // ignored here.
                ST_DRAIN: begin
                    if (stop_pending) begin
                        stop_pending <= 1'b0;
                    end else if (!driver_cout.busy) begin
                        timeout_fault[owner] <= 1'b1;
                        state                <= ST_IDLE;
                        owner_valid          <= 1'b0;
                        rr_ptr               <= next_port(owner);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef I2C_ARBITER_TIMEOUT_EN
    assign timeout_fault = '0;
`endif

    // Command mux. Only the owner's command reaches the transceiver; in any
    // other state the command is all zeros, so no strobe can leak through.
    always_comb begin
        driver_cin = '0;
        case (state)
            ST_BUSY:  driver_cin = client_cin[owner];
`ifdef I2C_ARBITER_TIMEOUT_EN
            ST_DRAIN: driver_cin.stop_en = stop_pending;
`endif
            default:  driver_cin = '0;
        endcase
    end

    // Status steering. Only the active owner sees the real status. Every
    // other port sees a permanently busy transceiver with no strobes.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            client_cout[p] = I2C_OUT_BLOCKED;
            if (state == ST_BUSY && owner == OW'(p))
                client_cout[p] = driver_cout;
        end
    end

endmodule

// File: tb/tb_i2c_driver_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_driver_arbiter
//
// Self-checking bench for i2c_driver_arbiter with NUM_PORTS=4. Expected grant
// order is pushed to a queue when requests are driven. A monitor pops the
// queue and compares whenever client_ack fires. The watchdog scenario runs
// only when I2C_ARBITER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=100).
// ---------------------------------------------------------------------------
module tb_i2c_driver_arbiter;
    import i2c_driver_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] client_request;
    logic [NP-1:0] client_done;
    logic [NP-1:0] client_ack;
    i2c_in_t       client_cin  [NP];
    i2c_out_t      client_cout [NP];
    i2c_in_t       driver_cin;
    i2c_out_t      driver_cout;
    logic [1:0]    owner;
    logic          owner_valid;
    logic [NP-1:0] timeout_fault;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];
    logic prev_valid = 1'b0;

    i2c_in_t  exp_cmd;
    i2c_out_t exp_stat;
    i2c_out_t blocked;

    i2c_driver_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .client_request (client_request),
        .client_done    (client_done),
        .client_ack     (client_ack),
        .client_cin     (client_cin),
        .client_cout    (client_cout),
        .driver_cin     (driver_cin),
        .driver_cout    (driver_cout),
        .owner          (owner),
        .owner_valid    (owner_valid),
        .timeout_fault  (timeout_fault)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // One-cycle pulse on request/done, driven just after a rising edge and
    // sampled by the next one. Returns #1 after that sampling edge.
    task automatic applyStimulus(input logic [NP-1:0] req, input logic [NP-1:0] done);
        @(posedge clk); #1;
        client_request = req;
        client_done    = done;
        @(posedge clk); #1;
        client_request = '0;
        client_done    = '0;
    endtask

    // Bounded wait until the given port owns the bus.
    task automatic waitOwner(input int port);
        int n = 0;
        while (!(owner_valid && int'(owner) == port) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput($sformatf("wait_owner_%0d", port),
                    32'(owner_valid && int'(owner) == port), 32'd1);
    endtask

    // Grant scoreboard: every ack must be one-hot, follow an idle cycle, and
    // match the next expected grant in order.
    always @(negedge clk) begin
        int p;
        int e;
        if (!rst && client_ack != '0) begin
            p = 0;
            for (int i = 0; i < NP; i++)
                if (client_ack[i]) p = i;
            checkOutput("ack_onehot", 32'($countones(client_ack)), 32'd1);
            checkOutput("idle_gap", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_grant", 32'(p), 32'hFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("grant_port", 32'(p), 32'(e));
                checkOutput("grant_owner", 32'(owner), 32'(e));
            end
        end
        prev_valid = owner_valid;
    end

    initial begin
        rst            = 1'b1;
        client_request = '0;
        client_done    = '0;
        driver_cout    = '0;
        for (int i = 0; i < NP; i++) client_cin[i] = '0;
        blocked = '{busy: 1'b1, default: '0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ack", 32'(client_ack), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_valid", 32'(owner_valid), 32'd0);
        checkOutput("rst_cmd", 32'(driver_cin), 32'd0);
        checkOutput("rst_fault", 32'(timeout_fault), 32'd0);
        for (int i = 0; i < NP; i++)
            checkOutput($sformatf("rst_cout_%0d", i), 32'(client_cout[i]), 32'(blocked));
        rst = 1'b0;

        // Contention: ports 0, 1 and 3 at once, rr_ptr=0 -> 0, 1, 3
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        applyStimulus(4'b1011, 4'b0000);
        checkOutput("contention_first_ack", 32'(client_ack), 32'b0001);
        waitOwner(0);
        applyStimulus(4'b0000, 4'b0001);
        waitOwner(1);
        applyStimulus(4'b0000, 4'b0010);
        waitOwner(3);

        // Round-robin wrap, with done and new requests in the same cycle
        exp_q.push_back(0);
        exp_q.push_back(2);
        applyStimulus(4'b0101, 4'b1000);
        checkOutput("done_releases", 32'(owner_valid), 32'd0);
        waitOwner(0);
        applyStimulus(4'b0000, 4'b0001);
        waitOwner(2);
        applyStimulus(4'b0000, 4'b0100);

        // Single client on port 2
        exp_q.push_back(2);
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("single_ack", 32'(client_ack), 32'b0100);
        checkOutput("single_owner", 32'(owner), 32'd2);
        checkOutput("single_valid", 32'(owner_valid), 32'd1);
        @(posedge clk); #1;
        checkOutput("ack_one_cycle", 32'(client_ack), 32'd0);
        exp_cmd = '{tx_en: 1'b1, tx_data: 8'h44, default: '0};
        client_cin[2] = exp_cmd;
        exp_stat = '{busy: 1'b1, rx_valid: 1'b1, rx_data: 8'hA5, default: '0};
        driver_cout = exp_stat;
        #1;
        checkOutput("single_cmd", 32'(driver_cin), 32'(exp_cmd));
        checkOutput("single_status", 32'(client_cout[2]), 32'(exp_stat));
        checkOutput("other_status", 32'(client_cout[0]), 32'(blocked));
        applyStimulus(4'b0000, 4'b0100);
        checkOutput("single_release", 32'(owner_valid), 32'd0);
        checkOutput("idle_cmd", 32'(driver_cin), 32'd0);
        checkOutput("idle_status", 32'(client_cout[2]), 32'(blocked));
        client_cin[2] = '0;
        driver_cout   = '0;

        // Isolation during port 1 ownership (rr_ptr=3)
        exp_q.push_back(1);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("iso_owner", 32'(owner), 32'd1);
        client_cin[0] = '{start_en: 1'b1, default: '0};
        exp_cmd = '{rx_en: 1'b1, default: '0};
        client_cin[1] = exp_cmd;
        driver_cout = '{rx_valid: 1'b1, rx_data: 8'h3C, default: '0};
        #1;
        checkOutput("iso_start", 32'(driver_cin.start_en), 32'd0);
        checkOutput("iso_cmd", 32'(driver_cin), 32'(exp_cmd));
        checkOutput("iso_rx_owner", 32'({client_cout[1].rx_valid, client_cout[1].rx_data}), 32'h13C);
        checkOutput("iso_busy_p0", 32'(client_cout[0].busy), 32'd1);
        checkOutput("iso_rx_p0", 32'(client_cout[0].rx_valid), 32'd0);
        checkOutput("iso_rx_p3", 32'(client_cout[3].rx_valid), 32'd0);
        applyStimulus(4'b0000, 4'b0010);
        client_cin[0] = '0;
        client_cin[1] = '0;
        driver_cout   = '0;

        // Stray done, then reset mid-BUSY with port 3 pending
        exp_q.push_back(0);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("stray_owner_before", 32'(owner), 32'd0);
        applyStimulus(4'b1000, 4'b0100);
        checkOutput("stray_done_valid", 32'(owner_valid), 32'd1);
        checkOutput("stray_done_owner", 32'(owner), 32'd0);
        client_cin[0] = '{tx_en: 1'b1, tx_data: 8'h11, default: '0};
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_valid", 32'(owner_valid), 32'd0);
        checkOutput("midrst_cmd", 32'(driver_cin), 32'd0);
        checkOutput("midrst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        client_cin[0] = '0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pending_cleared", 32'(owner_valid), 32'd0);

`ifdef I2C_ARBITER_TIMEOUT_EN
        // Watchdog: port 1 never sends done, port 3 waits behind it
        begin
            int n;
            exp_q.push_back(1);
            exp_q.push_back(3);
            driver_cout = '{busy: 1'b1, default: '0};
            applyStimulus(4'b0010, 4'b0000);
            applyStimulus(4'b1000, 4'b0000);
            n = 2;
            while (!driver_cin.stop_en && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("timeout_latency", 32'(n), 32'(TO));
            exp_cmd = '{stop_en: 1'b1, default: '0};
            checkOutput("drain_cmd", 32'(driver_cin), 32'(exp_cmd));
            @(posedge clk); #1;
            checkOutput("stop_one_cycle", 32'(driver_cin.stop_en), 32'd0);
            checkOutput("drain_no_fault", 32'(timeout_fault), 32'd0);
            driver_cout = '0;
            @(posedge clk); #1;
            checkOutput("fault_pulse", 32'(timeout_fault), 32'b0010);
            checkOutput("fault_release", 32'(owner_valid), 32'd0);
            @(posedge clk); #1;
            checkOutput("fault_once", 32'(timeout_fault), 32'd0);
            waitOwner(3);
            applyStimulus(4'b0000, 4'b1000);
        end
`else
        checkOutput("fault_tied_low", 32'(timeout_fault), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2c_driver_arbiter.md
Name: i2c_driver_arbiter

Overview:
- Shares one I2CTransceiver among NUM_PORTS I2C client controllers, such as I/O expander, sensor and EEPROM drivers.
- Each client sees a private driver interface: driver_request / driver_ack / driver_done plus i2c_in_t / i2c_out_t.
- The arbiter grants the bus round-robin and holds each grant for a whole transaction, until the client's done pulse.
- It muxes the owner's command struct to the transceiver and steers the status struct back to the owner.

Parameters:
- NUM_PORTS, default 4: number of client ports, 2..16.
- TIMEOUT_CYCLES, default 1000000: watchdog limit in clk cycles. Used only when I2C_ARBITER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- client_request  in  NUM_PORTS  one-cycle request pulse per client.
- client_done  in  NUM_PORTS  one-cycle release pulse per client.
- client_ack  out  NUM_PORTS  one-cycle grant pulse per client.
- client_cin  in  NUM_PORTS x i2c_in_t  per-client transceiver commands.
- client_cout  out  NUM_PORTS x i2c_out_t  per-client transceiver status.
- driver_cin  out  i2c_in_t  command to the shared I2CTransceiver.
- driver_cout  in  i2c_out_t  status from the shared I2CTransceiver.
- owner  out  clog2(NUM_PORTS)  index of the current owner, for debug.
- owner_valid  out  1  1 while the bus is granted.
- timeout_fault  out  NUM_PORTS  one-cycle fault pulse (timeout build only; otherwise tied to 0).

Behaviour:
- Reset values:
  - client_ack=0, owner=0, owner_valid=0, timeout_fault=0, pending=0, rr_ptr=0.
  - driver_cin is all zeros.
  - Reset mid-transaction drops ownership immediately without issuing a stop.
- Request latching:
  - A client_request pulse sets pending[i]. Requests are pulses, not levels, so they must never be lost.
  - A repeat request while pending[i] is already set has no effect.
  - A request from the current owner while it owns the bus is latched and served on a later grant.
- Grant selection:
  - The candidate set is pending | client_request.
  - Search starts at index rr_ptr and wraps modulo NUM_PORTS; the first set bit wins.
- FSM states:
  - IDLE: if the candidate set is non-empty at a clock edge, that edge does all of the following:
    - registers client_ack[w]=1 for exactly one cycle;
    - sets owner=w, owner_valid=1;
    - clears pending[w];
    - moves to BUSY.
    - Latency: request sampled at edge t gives ack high during cycle t..t+1.
  - BUSY: driver_cin = client_cin[owner], combinational mux with no added latency.
    - client_done[owner] moves to IDLE and sets rr_ptr=(owner+1) mod NUM_PORTS.
    - The earliest next grant is the edge after the one that samples done, so there is at least one idle cycle between owners.
    - client_done from a non-owner is ignored.
  - DRAIN (timeout build only): described under Optional Feature.
- Command mux:
  - In IDLE, driver_cin is all zeros, so no strobes reach the transceiver.
  - Non-owner client_cin is ignored completely.
- Status routing:
  - client_cout[owner] = driver_cout.
  - Every other port (and every port in IDLE) gets busy=1 and all other fields 0, so a mis-sequenced client can never see a spurious rx/ack strobe.
- Simultaneous events:
  - done and a new request in the same cycle: the request is latched and the done is honoured.
  - Requests from several ports in the same cycle: exactly one is granted and the rest stay pending.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,...,N-1,0.

Optional Feature:
- Macro: I2C_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on each grant and increments every BUSY cycle.
  - On reaching TIMEOUT_CYCLES, the arbiter moves to DRAIN.
  - DRAIN sends driver_cin all zeros except stop_en=1 for one cycle.
  - It then waits for driver_cout.busy=0.
  - It then pulses timeout_fault[owner] for one cycle, returns to IDLE and advances rr_ptr.
  - client_done during DRAIN is ignored.
- Undefined: no counter and no DRAIN state; timeout_fault is tied to 0; a client that never sends done hangs the bus.

Test Plan:
- Single client: request on port 2 at cycle 10 -> client_ack[2] high cycle 11 only, owner=2.
  - A client tx_en with tx_data=8'h44 appears on driver_cin the same cycle.
  - done at cycle 50 -> owner_valid=0 at cycle 51 and driver_cin all zeros.
- Contention: ports 0, 1 and 3 pulse request on the same cycle -> grants in order 0, 1, 3.
  - Each grant comes only after the previous owner's done, with no request lost.
- Isolation: during port 1 ownership, port 0 drives start_en=1 -> driver_cin.start_en stays 0.
  - client_cout[0].busy reads 1; rx strobes on driver_cout reach port 1 only.
- Round-robin wrap (NUM_PORTS=4): last owner 3, then ports 0 and 2 request -> port 0 granted first, then port 2.
- Stray done and reset: client_done[2] while port 0 owns -> no effect.
  - rst asserted mid-BUSY -> next cycle owner_valid=0, pending=0, driver_cin zeros.
- Timeout (macro defined, TIMEOUT_CYCLES=100): owner never sends done -> at BUSY cycle 100, stop_en pulses for one cycle.
  - After busy falls, timeout_fault[owner] pulses once and the next pending port is granted.
